countdown_timer_ctrl: RTL

//  Sequencing controller for the lab countdown timer: mm:ss BCD down-counter with start/pause/load FSM.

---
 rtl/countdown_timer_ctrl_pkg.sv | 27 ++
 rtl/countdown_timer_ctrl_if.sv | 26 ++
 rtl/countdown_timer_ctrl_bcd_digit_down.sv | 35 +++
 rtl/countdown_timer_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the countdown timer controller: FSM encoding,
// BCD digit limits and the preset clamp helper.
package countdown_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  DIG_MAX      = 4'd9;
    localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
    localparam logic [11:0] LEDS_ON      = 12'hFFF;
    localparam logic [11:0] LEDS_OFF     = 12'h000;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        logic [3:0] r;
        if (d > lim) begin
            r = lim;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Front-end bus of the countdown timer: pulses and presets in, BCD digits
// and status out.
interface countdown_timer_ctrl_if;
    logic        tick;
    logic        start_pause;
    logic        load;
    logic [7:0]  preset_min;
    logic [7:0]  preset_sec;
    logic [3:0]  q_out0;
    logic [3:0]  q_out1;
    logic [3:0]  q_out2;
    logic [3:0]  q_out3;
    logic        running;
    logic        stop;
    logic [11:0] all_leds;

    modport master (
        output tick, start_pause, load, preset_min, preset_sec,
        input  q_out0, q_out1, q_out2, q_out3, running, stop, all_leds
    );

    modport slave (
        input  tick, start_pause, load, preset_min, preset_sec,
        output q_out0, q_out1, q_out2, q_out3, running, stop, all_leds
    );
endinterface

// File: rtl/countdown_timer_ctrl_bcd_digit_down.sv
// One BCD down-counting digit with ripple borrow; wraps 0 -> MAX when a
// borrow arrives while enabled.
module bcd_digit_down #(
    parameter logic [3:0] MAX     = 4'd9,
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_borrow_in,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_q,
    output logic       o_borrow_out
);

    logic [3:0] r_q;

    // Digit register: reset, load, decrement-on-borrow, else hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_en && i_borrow_in) begin
            r_q <= (r_q == 4'd0) ? MAX : (r_q - 4'd1);
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q          = r_q;
    assign o_borrow_out = i_borrow_in && (r_q == 4'd0);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// mm:ss BCD countdown controller: IDLE/RUN/PAUSE/DONE FSM, preset clamp on
// load, and a four-digit ripple-borrow down-counter.
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter logic [7:0] PRESET_MIN = 8'h01,
    parameter logic [7:0] PRESET_SEC = 8'h30
) (
    input  logic                    clk,
    input  logic                    reset,
    countdown_timer_ctrl_if.slave   bus
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  w_q      [4];
    logic [3:0]  w_ld_val [4];
    logic [4:0]  w_borrow;
    logic        w_zero;
    logic        w_one;
    logic        w_dec;

    // The borrow chain seeded with 1 ripples out only when every digit is 0
    assign w_borrow[0] = 1'b1;
    assign w_zero      = w_borrow[4];
    assign w_one       = (w_q[3] == 4'd0) && (w_q[2] == 4'd0) &&
                         (w_q[1] == 4'd0) && (w_q[0] == 4'd1);

    assign w_dec = (r_state == ST_RUN) && bus.tick && !bus.start_pause &&
                   !bus.load && !w_zero;

    assign w_ld_val[0] = clamp_digit(bus.preset_sec[3:0], DIG_MAX);
    assign w_ld_val[1] = clamp_digit(bus.preset_sec[7:4], SEC_TENS_MAX);
    assign w_ld_val[2] = clamp_digit(bus.preset_min[3:0], DIG_MAX);
    assign w_ld_val[3] = clamp_digit(bus.preset_min[7:4], DIG_MAX);

    bcd_digit_down #(.MAX(DIG_MAX), .RST_VAL(PRESET_SEC[3:0])) u_dig0 (
        .clk(clk), .reset(reset), .i_en(w_dec), .i_borrow_in(w_borrow[0]),
        .i_load(bus.load), .i_load_val(w_ld_val[0]),
        .o_q(w_q[0]), .o_borrow_out(w_borrow[1])
    );

    bcd_digit_down #(.MAX(SEC_TENS_MAX), .RST_VAL(PRESET_SEC[7:4])) u_dig1 (
        .clk(clk), .reset(reset), .i_en(w_dec), .i_borrow_in(w_borrow[1]),
        .i_load(bus.load), .i_load_val(w_ld_val[1]),
        .o_q(w_q[1]), .o_borrow_out(w_borrow[2])
    );

    bcd_digit_down #(.MAX(DIG_MAX), .RST_VAL(PRESET_MIN[3:0])) u_dig2 (
        .clk(clk), .reset(reset), .i_en(w_dec), .i_borrow_in(w_borrow[2]),
        .i_load(bus.load), .i_load_val(w_ld_val[2]),
        .o_q(w_q[2]), .o_borrow_out(w_borrow[3])
    );

    bcd_digit_down #(.MAX(DIG_MAX), .RST_VAL(PRESET_MIN[7:4])) u_dig3 (
        .clk(clk), .reset(reset), .i_en(w_dec), .i_borrow_in(w_borrow[3]),
        .i_load(bus.load), .i_load_val(w_ld_val[3]),
        .o_q(w_q[3]), .o_borrow_out(w_borrow[4])
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; load outranks start_pause, which outranks tick
    always_comb begin
        w_next = r_state;
        if (bus.load) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_pause) begin
                        w_next = w_zero ? ST_DONE : ST_RUN;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.start_pause) begin
                        w_next = ST_PAUSE;
                    end else if (bus.tick && (w_one || w_zero)) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start_pause) begin
                        w_next = ST_RUN;
                    end else begin
                        w_next = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    w_next = ST_DONE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q_out0   = w_q[0];
    assign bus.q_out1   = w_q[1];
    assign bus.q_out2   = w_q[2];
    assign bus.q_out3   = w_q[3];
    assign bus.running  = (r_state == ST_RUN);
    assign bus.stop     = (r_state == ST_DONE);
    assign bus.all_leds = (r_state == ST_DONE) ? LEDS_ON : LEDS_OFF;

endmodule
